// File: rtl/prf_debug_access_ctrl_pkg.sv
// Shared types and widths for the PRF debug-port sequencer and its arbiter.
package prf_debug_access_ctrl_pkg;

    localparam int unsigned PHY_LOG         = 7;
    localparam int unsigned DATA_W          = 64;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned OFF_LOG         = 3;
    localparam int unsigned NUM_BYTES       = DATA_W / BYTE_W;
    localparam int unsigned PRF_DBG_NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        CAP  = 2'd2,
        RSP  = 2'd3
    } prfDbgState_t;

    typedef struct packed {
        logic                  we;
        logic [PHY_LOG-1:0]    addr;
        logic [DATA_W-1:0]     wdata;
    } prfDbgReq_t;

endpackage

// File: rtl/prf_dbg_rr_arb.sv
// Two-way round-robin arbiter; grant is combinational, pointer moves to the
// requester that was not just served.
module prf_dbg_rr_arb
    import prf_debug_access_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [PRF_DBG_NUM_REQ-1:0] valid,
    output logic [PRF_DBG_NUM_REQ-1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = '0;
        if (en) begin
            if (valid[0] && valid[1]) begin
                gnt[ptr] = 1'b1;
            end else begin
                gnt = valid;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (|gnt) begin
            ptr <= ~gnt[1];
        end
    end

endmodule

// File: rtl/prf_debug_access_ctrl.sv
// Splits whole-register debug reads/writes from two requesters into eight
// byte accesses on the PRF debug port, with abort on loss of core halt.
module prf_debug_access_ctrl
    import prf_debug_access_ctrl_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      coreHalted_i,
    input  logic [PRF_DBG_NUM_REQ-1:0]                reqValid_i,
    output logic [PRF_DBG_NUM_REQ-1:0]                reqReady_o,
    input  logic [PRF_DBG_NUM_REQ-1:0]                reqWe_i,
    input  logic [PRF_DBG_NUM_REQ-1:0][PHY_LOG-1:0]   reqAddr_i,
    input  logic [PRF_DBG_NUM_REQ-1:0][DATA_W-1:0]    reqWrData_i,
    output logic                                      rspValid_o,
    output logic                                      rspId_o,
    output logic                                      rspErr_o,
    output logic [DATA_W-1:0]                         rspRdData_o,
    output logic [PHY_LOG+OFF_LOG-1:0]                debugPRFAddr_o,
    output logic [BYTE_W-1:0]                         debugPRFWrData_o,
    output logic                                      debugPRFWrEn_o,
    input  logic [BYTE_W-1:0]                         debugPRFRdData_i,
    output logic                                      busy_o
);

    localparam logic [OFF_LOG-1:0] K_LAST = OFF_LOG'(NUM_BYTES - 1);
    localparam logic [OFF_LOG-1:0] K_ONE  = OFF_LOG'(1);

    prfDbgState_t                         state;
    prfDbgReq_t                           req_q;
    logic                                 id_q;
    logic                                 err_q;
    logic [OFF_LOG-1:0]                   k;
    logic [NUM_BYTES-1:0][BYTE_W-1:0]     rd_q;
    logic [NUM_BYTES-1:0][BYTE_W-1:0]     wr_bytes;
    logic [PRF_DBG_NUM_REQ-1:0]           gnt;
    logic                                 arb_en;
    logic                                 accept;
    logic                                 acc_id;
    logic                                 in_xfer;
    logic                                 in_rsp;

    assign arb_en = (state == IDLE) && coreHalted_i;

    prf_dbg_rr_arb u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .valid (reqValid_i),
        .gnt   (gnt)
    );

    assign reqReady_o = gnt;
    assign accept     = |gnt;
    assign acc_id     = gnt[1];

    // Sequencer: byte k's read data arrives one cycle after its address, so
    // XFER cycle k captures byte k-1 and CAP captures the last byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            req_q <= '0;
            id_q  <= 1'b0;
            err_q <= 1'b0;
            k     <= '0;
            rd_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_q <= '{we:    reqWe_i[acc_id],
                                   addr:  reqAddr_i[acc_id],
                                   wdata: reqWrData_i[acc_id]};
                        id_q  <= acc_id;
                        err_q <= 1'b0;
                        k     <= '0;
                        rd_q  <= '0;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (!coreHalted_i) begin
                        err_q <= 1'b1;
                        rd_q  <= '0;
                        k     <= '0;
                        state <= RSP;
                    end else begin
                        if (!req_q.we && (k != '0)) begin
                            rd_q[k - K_ONE] <= debugPRFRdData_i;
                        end
                        if (k == K_LAST) begin
                            k     <= '0;
                            state <= req_q.we ? RSP : CAP;
                        end else begin
                            k <= k + K_ONE;
                        end
                    end
                end
                CAP: begin
                    if (!coreHalted_i) begin
                        err_q <= 1'b1;
                        rd_q  <= '0;
                    end else begin
                        rd_q[K_LAST] <= debugPRFRdData_i;
                    end
                    state <= RSP;
                end
                RSP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign wr_bytes = req_q.wdata;
    assign in_xfer  = (state == XFER);
    assign in_rsp   = (state == RSP);

    // Port drive decodes straight from state flops so reset clears it at once.
    assign debugPRFWrEn_o   = in_xfer && req_q.we && coreHalted_i;
    assign debugPRFAddr_o   = in_xfer ? {req_q.addr, k} : '0;
    assign debugPRFWrData_o = (in_xfer && req_q.we) ? wr_bytes[k] : '0;

    assign rspValid_o  = in_rsp;
    assign rspId_o     = in_rsp && id_q;
    assign rspErr_o    = in_rsp && err_q;
    assign rspRdData_o = in_rsp ? rd_q : '0;
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_prf_debug_access_ctrl.sv
// Directed bench for prf_debug_access_ctrl with a byte-wide PRF model.
module tb_prf_debug_access_ctrl;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              coreHalted_i = 1'b0;
    logic [1:0]        reqValid_i = '0;
    logic [1:0]        reqReady_o;
    logic [1:0]        reqWe_i = '0;
    logic [1:0][6:0]   reqAddr_i = '0;
    logic [1:0][63:0]  reqWrData_i = '0;
    logic              rspValid_o;
    logic              rspId_o;
    logic              rspErr_o;
    logic [63:0]       rspRdData_o;
    logic [9:0]        debugPRFAddr_o;
    logic [7:0]        debugPRFWrData_o;
    logic              debugPRFWrEn_o;
    logic [7:0]        debugPRFRdData_i = '0;
    logic              busy_o;

    int tests  = 0;
    int failed = 0;

    logic [7:0] mem [0:1023];
    int         wr_cnt = 0;

    always #5 clk = ~clk;

    // PRF model: synchronous byte write, one-cycle read latency
    always @(posedge clk) begin
        if (debugPRFWrEn_o) begin
            mem[debugPRFAddr_o] <= debugPRFWrData_o;
            wr_cnt <= wr_cnt + 1;
        end
        debugPRFRdData_i <= mem[debugPRFAddr_o];
    end

    prf_debug_access_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .coreHalted_i     (coreHalted_i),
        .reqValid_i       (reqValid_i),
        .reqReady_o       (reqReady_o),
        .reqWe_i          (reqWe_i),
        .reqAddr_i        (reqAddr_i),
        .reqWrData_i      (reqWrData_i),
        .rspValid_o       (rspValid_o),
        .rspId_o          (rspId_o),
        .rspErr_o         (rspErr_o),
        .rspRdData_o      (rspRdData_o),
        .debugPRFAddr_o   (debugPRFAddr_o),
        .debugPRFWrData_o (debugPRFWrData_o),
        .debugPRFWrEn_o   (debugPRFWrEn_o),
        .debugPRFRdData_i (debugPRFRdData_i),
        .busy_o           (busy_o)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            if (rspValid_o) seen = 1'b1;
            else begin
                step();
                cyc++;
            end
        end
    endtask

    task automatic test_reset;
        logic [79:0] got;
        reset        = 1'b0;
        coreHalted_i = 1'b1;
        reqValid_i   = '0;
        repeat (2) step();
        got = {reqReady_o, rspValid_o, rspId_o, rspErr_o, busy_o, debugPRFWrEn_o,
               debugPRFAddr_o, rspRdData_o};
        tests++;
        if (got !== 80'h0) begin
            failed++;
            $display("FAIL reset_outputs got=%h want=0", got);
        end
        reset = 1'b1;
        step();
        tests++;
        if ({busy_o, debugPRFWrData_o} !== 9'h0) begin
            failed++;
            $display("FAIL reset_idle got busy=%b wdata=%h want 0/00", busy_o, debugPRFWrData_o);
        end
    endtask

    task automatic test_write;
        logic [7:0] exp_b [8] = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        logic [19:0] got, exp;
        reqValid_i     = 2'b01;
        reqWe_i        = 2'b01;
        reqAddr_i[0]   = 7'd5;
        reqWrData_i[0] = 64'h0123_4567_89AB_CDEF;
        #1;
        tests++;
        if (reqReady_o !== 2'b01) begin
            failed++;
            $display("FAIL write_ready got=%b want=01", reqReady_o);
        end
        step();
        reqValid_i = '0;
        for (int i = 0; i < 8; i++) begin
            got = {debugPRFWrEn_o, debugPRFAddr_o, debugPRFWrData_o, rspValid_o};
            exp = {1'b1, 10'(10'h28 + i), exp_b[i], 1'b0};
            tests++;
            if (got !== exp) begin
                failed++;
                $display("FAIL write_byte%0d got=%h want=%h", i, got, exp);
            end
            step();
        end
        tests++;
        if ({rspValid_o, rspId_o, rspErr_o, rspRdData_o} !== {3'b100, 64'h0}) begin
            failed++;
            $display("FAIL write_rsp got v=%b id=%b err=%b d=%h want 1/0/0/0",
                     rspValid_o, rspId_o, rspErr_o, rspRdData_o);
        end
        step();
        tests++;
        if ({busy_o, rspValid_o} !== 2'b00) begin
            failed++;
            $display("FAIL write_idle got busy=%b v=%b want 0/0", busy_o, rspValid_o);
        end
    endtask

    task automatic test_read;
        logic [10:0] got, exp;
        reqValid_i   = 2'b01;
        reqWe_i      = 2'b00;
        reqAddr_i[0] = 7'd5;
        #1;
        tests++;
        if (reqReady_o !== 2'b01) begin
            failed++;
            $display("FAIL read_ready got=%b want=01", reqReady_o);
        end
        step();
        reqValid_i = '0;
        for (int i = 0; i < 8; i++) begin
            got = {debugPRFWrEn_o, debugPRFAddr_o};
            exp = {1'b0, 10'(10'h28 + i)};
            tests++;
            if (got !== exp) begin
                failed++;
                $display("FAIL read_addr%0d got=%h want=%h", i, got, exp);
            end
            step();
        end
        tests++;
        if ({busy_o, rspValid_o, debugPRFWrEn_o, debugPRFAddr_o} !== {3'b100, 10'h0}) begin
            failed++;
            $display("FAIL read_cap got busy=%b v=%b we=%b a=%h want 1/0/0/000",
                     busy_o, rspValid_o, debugPRFWrEn_o, debugPRFAddr_o);
        end
        step();
        tests++;
        if ({rspValid_o, rspId_o, rspErr_o, rspRdData_o} !== {3'b100, 64'h0123_4567_89AB_CDEF}) begin
            failed++;
            $display("FAIL read_rsp got v=%b id=%b err=%b d=%h want 1/0/0/0123456789abcdef",
                     rspValid_o, rspId_o, rspErr_o, rspRdData_o);
        end
        step();
    endtask

    task automatic test_back_to_back;
        int n_acc = 0;
        int acc_id [4];
        int acc_cyc [4];
        int viol = 0;
        int c;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        step();
        reqWe_i        = 2'b11;
        reqAddr_i[0]   = 7'd10;
        reqAddr_i[1]   = 7'd11;
        reqWrData_i[0] = 64'hAAAA_0000_AAAA_0000;
        reqWrData_i[1] = 64'h5555_1111_5555_1111;
        reqValid_i     = 2'b11;
        #1;
        for (c = 0; c < 60 && n_acc < 4; c++) begin
            if (reqReady_o == 2'b11) viol++;
            if (busy_o && reqReady_o != 2'b00) viol++;
            if (reqReady_o != 2'b00) begin
                acc_id[n_acc]  = int'(reqReady_o[1]);
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            step();
        end
        reqValid_i = '0;
        tests++;
        if (n_acc !== 4) begin
            failed++;
            $display("FAIL b2b_count got=%0d want=4", n_acc);
        end else begin
            tests++;
            if ({acc_id[0], acc_id[1], acc_id[2], acc_id[3]} !== {32'd0, 32'd1, 32'd0, 32'd1}) begin
                failed++;
                $display("FAIL b2b_order got=%0d%0d%0d%0d want=0101",
                         acc_id[0], acc_id[1], acc_id[2], acc_id[3]);
            end
            tests++;
            if (acc_cyc[1] - acc_cyc[0] !== 10) begin
                failed++;
                $display("FAIL b2b_gap got=%0d want=10", acc_cyc[1] - acc_cyc[0]);
            end
        end
        tests++;
        if (viol !== 0) begin
            failed++;
            $display("FAIL b2b_ready_while_busy got=%0d want=0", viol);
        end
        c = 0;
        while (busy_o && c < 20) begin
            step();
            c++;
        end
    endtask

    task automatic test_halt;
        int nz = 0;
        int cyc;
        bit seen;
        coreHalted_i = 1'b0;
        reqValid_i   = 2'b10;
        reqWe_i      = 2'b00;
        reqAddr_i[1] = 7'd5;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (reqReady_o != 2'b00 || busy_o) nz++;
            step();
        end
        tests++;
        if (nz !== 0) begin
            failed++;
            $display("FAIL halt_blocked got=%0d want=0", nz);
        end
        coreHalted_i = 1'b1;
        #1;
        tests++;
        if (reqReady_o !== 2'b10) begin
            failed++;
            $display("FAIL halt_ready got=%b want=10", reqReady_o);
        end
        step();
        reqValid_i = '0;
        wait_rsp(cyc, seen);
        tests++;
        if ({seen, cyc[7:0], rspId_o, rspErr_o, rspRdData_o} !== {1'b1, 8'd9, 2'b10, 64'h0123_4567_89AB_CDEF}) begin
            failed++;
            $display("FAIL halt_rsp got seen=%b lat=%0d id=%b err=%b d=%h want 1/9/1/0/0123456789abcdef",
                     seen, cyc, rspId_o, rspErr_o, rspRdData_o);
        end
        step();
    endtask

    task automatic test_abort;
        int c0;
        logic [63:0] reg20;
        reqValid_i     = 2'b01;
        reqWe_i        = 2'b01;
        reqAddr_i[0]   = 7'd20;
        reqWrData_i[0] = 64'h1122_3344_5566_7788;
        #1;
        step();
        reqValid_i = '0;
        c0 = wr_cnt;
        repeat (3) step();
        coreHalted_i = 1'b0;
        #1;
        tests++;
        if ({busy_o, debugPRFWrEn_o} !== 2'b10) begin
            failed++;
            $display("FAIL abort_wren got busy=%b we=%b want 1/0", busy_o, debugPRFWrEn_o);
        end
        step();
        tests++;
        if ({rspValid_o, rspId_o, rspErr_o, rspRdData_o} !== {3'b101, 64'h0}) begin
            failed++;
            $display("FAIL abort_rsp got v=%b id=%b err=%b d=%h want 1/0/1/0",
                     rspValid_o, rspId_o, rspErr_o, rspRdData_o);
        end
        coreHalted_i = 1'b1;
        for (int k = 0; k < 8; k++) reg20[8*k +: 8] = mem[10'(160 + k)];
        tests++;
        if ({wr_cnt - c0, reg20} !== {32'd3, 64'h0000_0000_0066_7788}) begin
            failed++;
            $display("FAIL abort_bytes got n=%0d reg=%h want 3/0000000000667788", wr_cnt - c0, reg20);
        end
        step();
        tests++;
        if (busy_o !== 1'b0) begin
            failed++;
            $display("FAIL abort_idle got busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_reset_mid;
        int nrsp = 0;
        int cyc;
        bit seen;
        logic [77:0] got;
        reqValid_i   = 2'b01;
        reqWe_i      = 2'b00;
        reqAddr_i[0] = 7'd5;
        #1;
        step();
        reqValid_i = '0;
        repeat (2) step();
        #2;
        reset = 1'b0;
        #1;
        got = {busy_o, debugPRFWrEn_o, debugPRFAddr_o, rspValid_o, rspErr_o, rspRdData_o};
        tests++;
        if (got !== 78'h0) begin
            failed++;
            $display("FAIL rstmid_outputs got=%h want=0", got);
        end
        repeat (3) begin
            if (rspValid_o) nrsp++;
            step();
        end
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (rspValid_o || busy_o) nrsp++;
            step();
        end
        tests++;
        if (nrsp !== 0) begin
            failed++;
            $display("FAIL rstmid_no_rsp got=%0d want=0", nrsp);
        end
        reqValid_i     = 2'b10;
        reqWe_i        = 2'b10;
        reqAddr_i[1]   = 7'd7;
        reqWrData_i[1] = 64'hDEAD_BEEF_CAFE_F00D;
        #1;
        step();
        reqValid_i = '0;
        wait_rsp(cyc, seen);
        tests++;
        if ({seen, cyc[7:0], rspId_o, rspErr_o} !== {1'b1, 8'd8, 2'b10}) begin
            failed++;
            $display("FAIL rstmid_write got seen=%b lat=%0d id=%b err=%b want 1/8/1/0",
                     seen, cyc, rspId_o, rspErr_o);
        end
        step();
        reqValid_i   = 2'b01;
        reqWe_i      = 2'b00;
        reqAddr_i[0] = 7'd7;
        #1;
        step();
        reqValid_i = '0;
        wait_rsp(cyc, seen);
        tests++;
        if ({seen, rspId_o, rspErr_o, rspRdData_o} !== {3'b100, 64'hDEAD_BEEF_CAFE_F00D}) begin
            failed++;
            $display("FAIL rstmid_readback got seen=%b id=%b err=%b d=%h want 1/0/0/deadbeefcafef00d",
                     seen, rspId_o, rspErr_o, rspRdData_o);
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_halt();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
